shift_norm: RTL

Iterative normalizer for the 16-bit datapath. It computes the shift amount that the shifter stages consume. Given an operand, it shifts one bit per clock until the operand is normalized, then reports the normalized value and the shift count. Leading-zero count (left) or trailing-zero count (right) is selected per operation. It sits beside the combinational shifter and is driven by the control unit through a start/done/ack handshake.

---
 rtl/shift_norm.sv | 122 ++++++++++++
 1 files changed

// File: rtl/shift_norm.sv
// shift_norm - iterative one-bit-per-clock normalizer for the 16-bit datapath.
//
// Shifts an operand toward bit 15 (left, leading-zero count) or toward bit 0
// (right, trailing-zero count) until the target bit is set. It then reports
// the normalized value and the number of shifts taken. The control unit drives
// it through a start/done/ack handshake.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous active-high reset
//   In     in  16   operand, sampled on an accepted start
//   Dir    in   1   0 = normalize left (target bit 15), 1 = normalize right (target bit 0)
//   start  in   1   request, accepted only in IDLE
//   ack    in   1   result consumed, honoured only in DONE
//   busy   out  1   high in RUN and DONE
//   done   out  1   high in DONE; Out/Cnt valid
//   Out    out 16   normalized value
//   Cnt    out  5   shift count, 0..16 (16 only for a zero operand)
module shift_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] In,
  input  logic        Dir,
  input  logic        start,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] Out,
  output logic [4:0]  Cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] val;
  logic [4:0]  cnt;
  logic        dir;

  // Next value of val while in RUN, and whether it lands on the target bit.
  logic [15:0] shifted;
  logic        shifted_hit;
  // Whether a freshly presented operand is already normalized.
  logic        in_hit;

  // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
  always_comb begin
    shifted     = dir ? {1'b0, val[15:1]} : {val[14:0], 1'b0};
    shifted_hit = dir ? shifted[0] : shifted[15];
    in_hit      = Dir ? In[0] : In[15];
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      val   <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dir  <= Dir;
            busy <= 1'b1;
            if (In == 16'h0000) begin
              // Nothing to find: report the full width as the count.
              val   <= '0;
              cnt   <= 5'd16;
              state <= DONE;
              done  <= 1'b1;
            end else if (in_hit) begin
              val   <= In;
              cnt   <= '0;
              state <= DONE;
              done  <= 1'b1;
            end else begin
              val   <= In;
              cnt   <= '0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          // val is never zero here, so this terminates within 15 shifts.
          val <= shifted;
          cnt <= cnt + 5'd1;
          if (shifted_hit) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          // A coincident start is dropped; only ack matters here.
          if (ack) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign Out = val;
  assign Cnt = cnt;

endmodule
